// File: rtl/sys_bus_arbiter_if.sv
// sys_bus bundle between NM single-strobe masters, the arbiter and one downstream target.
// slave modport is the arbiter's view; master modport is the surrounding environment's view.
// Widths follow the NM/AW/DW parameters, which must match those of the arbiter instance.
interface sys_bus_arbiter_if #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 32
);
  // upstream (master side)
  logic [NM-1:0]    m_wen_i;
  logic [NM-1:0]    m_ren_i;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM*DW-1:0] m_wdata_i;
  logic [NM-1:0]    m_ack_o;
  logic             m_err_o;
  logic [DW-1:0]    m_rdata_o;
  // downstream (target side)
  logic             s_wen_o;
  logic             s_ren_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW-1:0]    s_wdata_o;
  logic             s_ack_i;
  logic             s_err_i;
  logic [DW-1:0]    s_rdata_i;

  modport slave (
    input  m_wen_i, m_ren_i, m_addr_i, m_wdata_i, s_ack_i, s_err_i, s_rdata_i,
    output m_ack_o, m_err_o, m_rdata_o, s_wen_o, s_ren_o, s_addr_o, s_wdata_o
  );

  modport master (
    output m_wen_i, m_ren_i, m_addr_i, m_wdata_i, s_ack_i, s_err_i, s_rdata_i,
    input  m_ack_o, m_err_o, m_rdata_o, s_wen_o, s_ren_o, s_addr_o, s_wdata_o
  );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter funnelling NM single-strobe sys_bus masters onto one downstream target.
// Latency: master strobe in cycle N -> downstream strobe in N+2 when idle; m_ack_o one cycle after s_ack_i.
// Backpressure: one pending slot per master; strobes from a master with a pending request are dropped.
module sys_bus_arbiter #(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  sys_bus_arbiter_if.slave bus
);

  localparam int         GW      = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // per-master pending slot: valid, type (1 = write), address, write data
  logic [NM-1:0] pend_vld;
  logic [NM-1:0] pend_wr;
  logic [AW-1:0] pend_addr  [NM];
  logic [DW-1:0] pend_wdata [NM];

  // arbitration and in-flight transaction bookkeeping
  logic [GW-1:0] rr_start;   // first master examined by the next round-robin search
  logic [GW-1:0] sel_idx;
  logic          sel_found;
  logic [GW:0]   scan;
  logic [GW-1:0] grant_idx;
  logic          grant_wr;
  logic [7:0]    cnt;

  // control decisions for the current cycle
  logic          do_grant;
  logic          ack_hit;
  logic          to_hit;
  logic          complete;
  logic [NM-1:0] grant_vec;

  // capture new strobes into free pending slots; release the granted slot on completion
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend_vld <= '0;
      pend_wr  <= '0;
      for (int i = 0; i < NM; i++) begin
        pend_addr[i]  <= '0;
        pend_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NM; i++) begin
        if (complete && (grant_idx == GW'(i))) begin
          pend_vld[i] <= 1'b0;
        end else if (!pend_vld[i] && (bus.m_wen_i[i] || bus.m_ren_i[i])) begin
          // write wins when both strobes arrive together; the read is dropped
          pend_vld[i]   <= 1'b1;
          pend_wr[i]    <= bus.m_wen_i[i];
          pend_addr[i]  <= bus.m_addr_i[i*AW +: AW];
          pend_wdata[i] <= bus.m_wdata_i[i*DW +: DW];
        end
      end
    end
  end

  // round-robin search over pending slots starting at rr_start
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NM; k++) begin
      scan = {1'b0, rr_start} + (GW+1)'(k);
      if (scan >= (GW+1)'(NM)) begin
        scan = scan - (GW+1)'(NM);
      end
      if (!sel_found && pend_vld[scan[GW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan[GW-1:0];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: IDLE grants when anything is pending, WAIT ends on ack or timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (sel_found) state_nxt = WAIT;
      WAIT: if (bus.s_ack_i || (cnt == TO_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: one-cycle control decisions; a real ack beats a simultaneous timeout
  always_comb begin
    do_grant  = (state == IDLE) && sel_found;
    ack_hit   = (state == WAIT) && bus.s_ack_i;
    to_hit    = (state == WAIT) && !bus.s_ack_i && (cnt == TO_LAST);
    complete  = ack_hit || to_hit;
    grant_vec = '0;
    grant_vec[grant_idx] = 1'b1;
  end

  // downstream side: launch the granted request, hold addr/data, run the timeout counter
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bus.s_wen_o   <= 1'b0;
      bus.s_ren_o   <= 1'b0;
      bus.s_addr_o  <= '0;
      bus.s_wdata_o <= '0;
      grant_idx     <= '0;
      grant_wr      <= 1'b0;
      rr_start      <= '0;
      cnt           <= '0;
    end else begin
      bus.s_wen_o <= 1'b0;
      bus.s_ren_o <= 1'b0;
      if (do_grant) begin
        bus.s_wen_o   <= pend_wr[sel_idx];
        bus.s_ren_o   <= ~pend_wr[sel_idx];
        bus.s_addr_o  <= pend_addr[sel_idx];
        bus.s_wdata_o <= pend_wdata[sel_idx];
        grant_idx     <= sel_idx;
        grant_wr      <= pend_wr[sel_idx];
        rr_start      <= (sel_idx == GW'(NM - 1)) ? '0 : sel_idx + 1'b1;
        cnt           <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // upstream side: one-cycle ack to the granted master; err/rdata hold between acks
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bus.m_ack_o   <= '0;
      bus.m_err_o   <= 1'b0;
      bus.m_rdata_o <= '0;
    end else begin
      bus.m_ack_o <= '0;
      if (ack_hit) begin
        bus.m_ack_o   <= grant_vec;
        bus.m_err_o   <= bus.s_err_i;
        bus.m_rdata_o <= grant_wr ? '0 : bus.s_rdata_i;
      end else if (to_hit) begin
        bus.m_ack_o   <= grant_vec;
        bus.m_err_o   <= 1'b1;
        bus.m_rdata_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Bench for sys_bus_arbiter: directed scenarios then random traffic against a transaction-level model.
// Expected downstream strobes and master acks are queued at grant time; a monitor pops and compares.
// The bench also plays the downstream target, with ack timing chosen by the model.
module tb_sys_bus_arbiter;
  localparam int NM      = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 32;
  localparam int INF     = 32'h7fff_ffff;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;

  sys_bus_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

  sys_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int            at;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ds_t;

  typedef struct {
    int            at;
    int            m;
    bit            err;
    logic [DW-1:0] rdata;
  } ack_t;

  ds_t  exp_ds[$];
  ack_t exp_ack[$];

  // model state
  bit            pend    [NM];
  bit            pwr     [NM];
  logic [AW-1:0] paddr   [NM];
  logic [DW-1:0] pdata   [NM];
  int            vis_at  [NM];
  int            done_at [NM];
  int            rr_next, free_at;
  int            ack_cyc, stray_cyc;
  bit            ack_err;
  logic [DW-1:0] ack_rdata;

  // stimulus knobs
  logic [AW-1:0] drv_addr [NM];
  logic [DW-1:0] drv_data [NM];
  int            ack_mode;          // 0 random plan, 1 fixed delay
  int            fixed_d;           // 0 means never ack
  bit            use_fixed_rdata;
  logic [DW-1:0] fixed_rdata;
  int            last_t;

  int checks = 0;
  int passed = 0;
  int exp_ack_total = 0;
  int seen_ack_total = 0;
  int snap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic model_reset();
    for (int m = 0; m < NM; m++) begin
      pend[m] = 1'b0; vis_at[m] = 0; done_at[m] = INF;
    end
    rr_next = 0; free_at = 0; ack_cyc = -1; stray_cyc = -1;
    exp_ack_total -= exp_ack.size();
    exp_ack.delete();
    exp_ds.delete();
  endtask

  task automatic rand_drv();
    for (int m = 0; m < NM; m++) begin
      drv_addr[m] = $urandom;
      drv_data[m] = $urandom;
    end
  endtask

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int m = 0; m < NM; m++) r |= pend[m];
    return r;
  endfunction

  // one clock cycle: drive masters and target, advance the model
  task automatic cycle(input logic [NM-1:0] wen, input logic [NM-1:0] ren);
    int t, g, s, c, d, cand, r;
    bit found, tmo, er;
    logic [DW-1:0] rd, erd;
    @(posedge clk_i); #1;
    t = cyc; last_t = t;
    for (int m = 0; m < NM; m++) if (pend[m] && done_at[m] <= t) pend[m] = 1'b0;
    bus.m_wen_i = wen;
    bus.m_ren_i = ren;
    for (int m = 0; m < NM; m++) begin
      bus.m_addr_i[m*AW +: AW]  = drv_addr[m];
      bus.m_wdata_i[m*DW +: DW] = drv_data[m];
      if ((wen[m] || ren[m]) && !pend[m]) begin
        pend[m] = 1'b1; pwr[m] = wen[m]; paddr[m] = drv_addr[m]; pdata[m] = drv_data[m];
        vis_at[m] = t + 1; done_at[m] = INF;
      end
    end
    if (t == ack_cyc) begin
      bus.s_ack_i = 1'b1; bus.s_err_i = ack_err; bus.s_rdata_i = ack_rdata;
    end else if (t == stray_cyc) begin
      bus.s_ack_i = 1'b1; bus.s_err_i = 1'b1; bus.s_rdata_i = $urandom;
    end else begin
      bus.s_ack_i = 1'b0; bus.s_err_i = 1'($urandom); bus.s_rdata_i = $urandom;
    end
    found = 1'b0; g = 0;
    if (t >= free_at) begin
      for (int k = 0; k < NM; k++) begin
        cand = (rr_next + k) % NM;
        if (!found && pend[cand] && vis_at[cand] <= t) begin
          found = 1'b1; g = cand;
        end
      end
    end
    if (found) begin
      s = t + 1;
      exp_ds.push_back('{at: s, wr: pwr[g], addr: paddr[g], data: pdata[g]});
      tmo = 1'b0; d = 1;
      if (ack_mode == 0) begin
        r = $urandom_range(0, 9);
        if (r == 0)      tmo = 1'b1;
        else if (r == 1) d = TIMEOUT - 1;
        else             d = $urandom_range(1, 3);
        er = 1'($urandom_range(0, 1));
      end else begin
        tmo = (fixed_d == 0); d = fixed_d; er = 1'b0;
      end
      rd = use_fixed_rdata ? fixed_rdata : DW'($urandom);
      if (tmo) begin
        c = s + TIMEOUT - 1; ack_cyc = -1;
        erd = '0;
        exp_ack.push_back('{at: c + 1, m: g, err: 1'b1, rdata: erd});
      end else begin
        c = s + d; ack_cyc = c; ack_err = er; ack_rdata = rd;
        erd = pwr[g] ? '0 : rd;
        exp_ack.push_back('{at: c + 1, m: g, err: er, rdata: erd});
      end
      exp_ack_total++;
      done_at[g] = c + 1; free_at = c + 1; rr_next = (g + 1) % NM;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_ack.size() != 0 || any_pend()) && n < 200) begin
      cycle('0, '0); n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL drain_bound: transactions still outstanding after %0d cycles", n);
    end
    cycle('0, '0);
    cycle('0, '0);
  endtask

  task automatic reset_outputs_chk();
    chk("rst_m_ack",   bus.m_ack_o,   0);
    chk("rst_m_err",   bus.m_err_o,   0);
    chk("rst_m_rdata", bus.m_rdata_o, 0);
    chk("rst_s_wen",   bus.s_wen_o,   0);
    chk("rst_s_ren",   bus.s_ren_o,   0);
    chk("rst_s_addr",  bus.s_addr_o,  0);
    chk("rst_s_wdata", bus.s_wdata_o, 0);
  endtask

  task automatic mon_step();
    ds_t  e;
    ack_t a;
    if (!rstn_i) return;
    if (bus.s_wen_o || bus.s_ren_o) begin
      if (exp_ds.size() == 0) chk("ds_unexpected", {bus.s_wen_o, bus.s_ren_o}, 0);
      else begin
        e = exp_ds.pop_front();
        chk("ds_cycle", cyc, e.at);
        chk("ds_type", {bus.s_wen_o, bus.s_ren_o}, e.wr ? 2'b10 : 2'b01);
        chk("ds_addr", bus.s_addr_o, e.addr);
        if (e.wr) chk("ds_wdata", bus.s_wdata_o, e.data);
      end
    end
    if (bus.m_ack_o != '0) begin
      seen_ack_total++;
      if (exp_ack.size() == 0) chk("ack_unexpected", bus.m_ack_o, 0);
      else begin
        a = exp_ack.pop_front();
        chk("ack_cycle", cyc, a.at);
        chk("ack_vector", bus.m_ack_o, NM'(1) << a.m);
        chk("ack_err", bus.m_err_o, a.err);
        chk("ack_rdata", bus.m_rdata_o, a.rdata);
      end
    end
  endtask

  initial begin
    int t0;
    logic [NM-1:0] w, rr;
    bus.m_wen_i = '0; bus.m_ren_i = '0; bus.m_addr_i = '0; bus.m_wdata_i = '0;
    bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rdata_i = '0;
    for (int m = 0; m < NM; m++) begin drv_addr[m] = '0; drv_data[m] = '0; end
    ack_mode = 1; fixed_d = 1; use_fixed_rdata = 1'b0; fixed_rdata = '0; last_t = 0;
    model_reset();
    fork
      forever begin @(negedge clk_i); mon_step(); end
    join_none

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_outputs_chk();
    @(posedge clk_i); #1; rstn_i = 1'b1;

    // single write from master 0, ack one cycle after the downstream strobe
    ack_mode = 1; fixed_d = 1;
    drv_addr[0] = 32'h4000_0010; drv_data[0] = 32'hDEAD_BEEF;
    cycle(2'b01, 2'b00);
    drain();

    // read from master 1, ack two cycles after the downstream strobe
    fixed_d = 2; use_fixed_rdata = 1'b1; fixed_rdata = 32'h1234_5678;
    drv_addr[1] = 32'h4010_0000;
    cycle(2'b00, 2'b10);
    drain();
    use_fixed_rdata = 1'b0;

    // read that times out, followed by a late ack that must be ignored
    fixed_d = 0; rand_drv();
    snap = seen_ack_total;
    cycle(2'b00, 2'b10);
    t0 = last_t; stray_cyc = t0 + 40;
    while (last_t < t0 + 45) cycle('0, '0);
    chk("timeout_one_ack_only", seen_ack_total - snap, 1);
    stray_cyc = -1;

    // write+read together, then a second strobe while pending
    fixed_d = 1; rand_drv();
    cycle(2'b01, 2'b01);
    rand_drv();
    cycle(2'b00, 2'b01);
    cycle(2'b01, 2'b00);
    drain();

    // reset two cycles after the downstream strobe of a never-acked write
    fixed_d = 0; rand_drv();
    cycle(2'b01, 2'b00);
    t0 = last_t;
    while (last_t < t0 + 3) cycle('0, '0);
    @(posedge clk_i); #1;
    rstn_i = 1'b0;
    bus.m_wen_i = '0; bus.m_ren_i = '0; bus.s_ack_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    reset_outputs_chk();
    @(posedge clk_i); @(posedge clk_i); #1;
    rstn_i = 1'b1;
    snap = seen_ack_total;
    repeat (40) cycle('0, '0);
    chk("no_ack_after_reset", seen_ack_total - snap, 0);

    // contention from a freshly reset pointer, then again
    fixed_d = 1;
    rand_drv(); cycle(2'b11, 2'b00); drain();
    rand_drv(); cycle(2'b01, 2'b10); drain();

    // random traffic
    ack_mode = 0;
    for (int i = 0; i < 1500; i++) begin
      rand_drv();
      w = '0; rr = '0;
      for (int m = 0; m < NM; m++) begin
        case ($urandom_range(0, 7))
          0: w[m] = 1'b1;
          1: rr[m] = 1'b1;
          2: begin w[m] = 1'b1; rr[m] = 1'b1; end
          default: ;
        endcase
      end
      cycle(w, rr);
    end
    drain();

    chk("ds_queue_empty", exp_ds.size(), 0);
    chk("ack_queue_empty", exp_ack.size(), 0);
    chk("ack_total", seen_ack_total, exp_ack_total);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
